i2c_slave_read_byte: RTL and testbench

//   Slave-side byte receiver: shifts in one 8-bit byte driven by the master on SDA,

---
 rtl/i2c_slave_read_byte_pkg.sv | 20 ++
 rtl/i2c_slave_read_byte_line_sync.sv | 48 ++++
 rtl/i2c_slave_read_byte.sv | 87 ++++++++
 tb/tb_i2c_slave_read_byte.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_read_byte_pkg.sv
// Shared definitions for the I2C slave byte receiver: state encoding,
// byte width and synchronizer depth default.
package i2c_slave_read_byte_pkg;

  localparam int I2C_BYTE_BITS       = 8;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  function automatic logic [I2C_BYTE_BITS-1:0] shift_in(
    input logic [I2C_BYTE_BITS-1:0] cur,
    input logic                     bit_in
  );
    return {cur[I2C_BYTE_BITS-2:0], bit_in};
  endfunction

endpackage

// File: rtl/i2c_slave_read_byte_line_sync.sv
// SCL/SDA synchronizer plus one history flop per line; decodes SCL rising
// edge and START/STOP (SDA moving while SCL is held high).
module i2c_slave_read_byte_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_s,
  output logic o_scl_rise,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl_s;
  logic                   w_sda_s;
  logic                   w_scl_high;

  // Everything presets to 1 so a reset never manufactures an edge on an idle bus.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl_s;
      r_sda_prev <= w_sda_s;
    end
  end

  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_high = w_scl_s & r_scl_prev;

  assign o_sda_s    = w_sda_s;
  assign o_scl_rise = w_scl_s & ~r_scl_prev;
  assign o_start    = w_scl_high & r_sda_prev & ~w_sda_s;
  assign o_stop     = w_scl_high & ~r_sda_prev & w_sda_s;

endmodule

// File: rtl/i2c_slave_read_byte.sv
// Slave-side byte receiver: shifts in 8 bits MSB first on SCL rising edges,
// pulses finish with the byte, or bus_error if START/STOP interrupts it.
module i2c_slave_read_byte
  import i2c_slave_read_byte_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     scl,
  input  logic                     sda,
  output logic [I2C_BYTE_BITS-1:0] data,
  output logic                     finish,
  output logic                     bus_error
);

  rx_state_t                r_state;
  logic [2:0]               r_bit_cnt;
  logic [I2C_BYTE_BITS-1:0] r_shift;
  logic [I2C_BYTE_BITS-1:0] r_data;
  logic                     r_finish;
  logic                     r_bus_error;

  logic                     w_sda_s;
  logic                     w_scl_rise;
  logic                     w_start;
  logic                     w_stop;

  i2c_slave_read_byte_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clock    (clock),
    .i_reset_n  (reset_n),
    .i_scl      (scl),
    .i_sda      (sda),
    .o_sda_s    (w_sda_s),
    .o_scl_rise (w_scl_rise),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  // A rise can never coincide with START/STOP (they need SCL already high),
  // but checking the rise first keeps data sampling the priority anyway.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= '0;
      r_data      <= '0;
      r_finish    <= 1'b0;
      r_bus_error <= 1'b0;
    end else begin
      r_finish    <= 1'b0;
      r_bus_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state   <= ST_SHIFT;
            r_bit_cnt <= 3'd0;
          end
        end
        ST_SHIFT: begin
          if (w_scl_rise) begin
            r_shift   <= shift_in(r_shift, w_sda_s);
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_data   <= shift_in(r_shift, w_sda_s);
              r_finish <= 1'b1;
              r_state  <= ST_IDLE;
            end
          end else if (w_start || w_stop) begin
            r_bus_error <= 1'b1;
            r_shift     <= '0;
            r_bit_cnt   <= 3'd0;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign data      = r_data;
  assign finish    = r_finish;
  assign bus_error = r_bus_error;

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Directed bench for i2c_slave_read_byte: models an I2C master with an
// 8-clk SCL period, SDA changing only mid-SCL-low except for START/STOP.
module tb_i2c_slave_read_byte;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic [7:0] data;
  logic       finish;
  logic       bus_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  int fin_cyc  = 0;
  int fin_cnt  = 0;
  int err_cnt  = 0;
  int viol     = 0;
  logic [7:0] fin_data = 8'h00;
  logic prev_f = 1'b0;
  logic prev_e = 1'b0;

  i2c_slave_read_byte #(.SYNC_STAGES(SYNC)) dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .scl       (scl),
    .sda       (sda),
    .data      (data),
    .finish    (finish),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (finish) begin
      fin_cnt  = fin_cnt + 1;
      fin_data = data;
      fin_cyc  = cyc;
    end
    if (bus_error) err_cnt = err_cnt + 1;
    if ((finish && bus_error) || (finish && prev_f) || (bus_error && prev_e))
      viol = viol + 1;
    prev_f = finish;
    prev_e = bus_error;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tick(2);
    sda = b;
    tick(2);
    scl = 1'b1;
    rise_cyc = cyc;
    tick(4);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
  endtask

  logic [7:0] seq [4] = '{8'h13, 8'h57, 8'h9B, 8'h0F};
  int f0, e0;

  initial begin
    // Reset
    tick(3);
    check_eq("reset_data", {24'h0, data}, 32'h00);
    check_eq("reset_finish", {31'h0, finish}, 32'h0);
    check_eq("reset_bus_error", {31'h0, bus_error}, 32'h0);
    reset_n = 1'b1;
    tick(2);

    // Test 1: single byte A5 with latency check
    scl = 1'b0;
    tick(4);
    f0 = fin_cnt; e0 = err_cnt;
    pulse_enable();
    send_byte(8'hA5);
    tick(4);
    check_eq("t1_finish_count", fin_cnt - f0, 1);
    check_eq("t1_data", {24'h0, data}, 32'hA5);
    check_eq("t1_fin_data", {24'h0, fin_data}, 32'hA5);
    check_eq("t1_latency_edges", fin_cyc - rise_cyc, SYNC + 1);
    check_eq("t1_errors", err_cnt - e0, 0);

    // Test 2: back-to-back bytes
    f0 = fin_cnt; e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      pulse_enable();
      send_byte(seq[k]);
      tick(4);
      check_eq($sformatf("t2_data_%0d", k), {24'h0, fin_data}, {24'h0, seq[k]});
    end
    check_eq("t2_finish_count", fin_cnt - f0, 4);
    check_eq("t2_errors", err_cnt - e0, 0);

    // Test 3: STOP after 3 bits (plus a 4th sampled bit)
    f0 = fin_cnt; e0 = err_cnt;
    pulse_enable();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    tick(2); sda = 1'b0;
    tick(2); scl = 1'b1;
    tick(2); sda = 1'b1;
    tick(6);
    check_eq("t3_bus_error_count", err_cnt - e0, 1);
    check_eq("t3_finish_count", fin_cnt - f0, 0);
    check_eq("t3_data_kept", {24'h0, data}, 32'h0F);
    check_eq("t3_state_idle", {31'h0, dut.r_state}, 32'h0);
    scl = 1'b0;
    tick(4);
    f0 = fin_cnt;
    pulse_enable();
    send_byte(8'hC3);
    tick(4);
    check_eq("t3_next_finish", fin_cnt - f0, 1);
    check_eq("t3_next_data", {24'h0, data}, 32'hC3);

    // Test 4: repeated START after 5 bits
    f0 = fin_cnt; e0 = err_cnt;
    pulse_enable();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    tick(2); sda = 1'b1;
    tick(2); scl = 1'b1;
    tick(3); sda = 1'b0;
    tick(5); scl = 1'b0;
    tick(4);
    check_eq("t4_bus_error_count", err_cnt - e0, 1);
    check_eq("t4_finish_count", fin_cnt - f0, 0);
    check_eq("t4_data_kept", {24'h0, data}, 32'hC3);

    // Test 5: reset mid-byte
    f0 = fin_cnt; e0 = err_cnt;
    pulse_enable();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_eq("t5_data_reset", {24'h0, data}, 32'h00);
    tick(4);
    check_eq("t5_no_pulses", (fin_cnt - f0) + (err_cnt - e0), 0);
    pulse_enable();
    send_byte(8'h3C);
    tick(4);
    check_eq("t5_data_after", {24'h0, data}, 32'h3C);
    check_eq("t5_finish_count", fin_cnt - f0, 1);

    // Test 6: extra enables mid-byte, then SCL activity without enable
    f0 = fin_cnt; e0 = err_cnt;
    pulse_enable();
    for (int i = 7; i >= 0; i--) begin
      send_bit(logic'((8'h81 >> i) & 8'h01));
      if (i == 5 || i == 2) pulse_enable();
    end
    tick(4);
    check_eq("t6_finish_count", fin_cnt - f0, 1);
    check_eq("t6_data", {24'h0, data}, 32'h81);
    f0 = fin_cnt;
    send_byte(8'h55);
    tick(4);
    check_eq("t6_idle_finish", fin_cnt - f0, 0);
    check_eq("t6_idle_data", {24'h0, data}, 32'h81);
    check_eq("t6_errors", err_cnt - e0, 0);

    check_eq("pulse_exclusive", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
